// File: rtl/final_ctrl_fsm.sv
// +------------------------------------------------------------------------+
// | final_ctrl_fsm : job sequencer issuing op indices over valid/ready;     |
// | optional abort support with FINAL_CTRL_ABORT_EN. Revision: 1.0          |
// +------------------------------------------------------------------------+
`default_nettype none

module final_ctrl_fsm #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_cnt_i,
  input  logic                 op_ready_i,
`ifdef FINAL_CTRL_ABORT_EN
  input  logic                 abort_i,
  output logic                 aborted_o,
`endif
  output logic                 op_valid_o,
  output logic [CNT_WIDTH-1:0] op_idx_o,
  output logic                 idle_o,
  output logic                 run_o,
  output logic                 done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] C_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] C_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 w_last;
  logic                 w_abort;

  // num is never 0 while in RUN, so num-1 cannot underflow here
  assign w_last = (cnt_q == (num_q - C_ONE));

`ifdef FINAL_CTRL_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_d   = num_cnt_i;
          cnt_d   = C_ZERO;
          state_d = (num_cnt_i == C_ZERO) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over normal completion; cnt cleared so op_idx_o idles at 0
        if (w_abort) begin
          state_d = S_DONE;
          cnt_d   = C_ZERO;
        end else if (op_ready_i) begin
          if (w_last) begin
            state_d = S_DONE;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = C_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num_q   <= C_ZERO;
      cnt_q   <= C_ZERO;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FINAL_CTRL_ABORT_EN
  logic aborted_q, aborted_d;

  always_comb begin
    aborted_d = (state_q == S_RUN) && abort_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted_o = aborted_q;
`endif

  assign idle_o     = (state_q == S_IDLE);
  assign run_o      = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign op_valid_o = (state_q == S_RUN);
  assign op_idx_o   = cnt_q;

endmodule

`default_nettype wire
